vm_change_dispenser: RTL and testbench

//  Parametrised change-return engine for the vending machine. Owns the inactivity

---
 rtl/vm_change_dispenser.sv | 213 +++++++++++++++++++++
 tb/tb_vm_change_dispenser.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vm_change_dispenser.sv
// rtl/vm_change_dispenser.sv - greedy coin change-return engine with inactivity countdown
//
// Purpose:
//   Owns the vending machine's inactivity countdown. A user return request or
//   a countdown timeout pays out the current balance. Payout is one coin per
//   cycle, chosen greedily with the largest fitting denomination first. Each
//   coin is offered to the coin hopper over a valid/ready handshake.
//
// Optional feature macro: VM_COIN_STOCK_EN
//   When defined, the engine keeps a stock counter per coin. Coins with no
//   stock are skipped, and the o_stock_empty port is added. When undefined,
//   stock is treated as unlimited.
//
// Ports:
//   clk              clock
//   reset_n          synchronous, active-low reset
//   i_input_coin     one-cycle strobe per inserted coin (one bit per denomination)
//   i_item_dispensed item vended this cycle
//   i_trigger_return user return request (level, sampled each edge)
//   i_total          current balance from the balance keeper
//   i_coin_ready     hopper accepts the presented coin
//   o_return_valid   a coin is presented
//   o_return_coin    one-hot presented coin, 0 when not valid
//   o_return_value   value of presented coin (keeper subtracts on transfer)
//   o_busy           payout in progress; upstream must reject coins/items
//   o_done           one-cycle pulse at end of payout
//   o_residue        unpayable remainder, valid with o_done
//   o_stock_empty    (VM_COIN_STOCK_EN only) bit i set when coin i stock is 0
//   o_wait_time      cycles left before timeout

module vm_change_dispenser #(
    parameter int                            NUM_COINS   = 3,
    parameter int                            TOTAL_BITS  = 31,
    parameter int                            VAL_BITS    = 16,
    parameter logic [NUM_COINS*VAL_BITS-1:0] COIN_VALUES = {16'd1000, 16'd500, 16'd100},
    parameter int                            WAIT_CYCLES = 10,
`ifdef VM_COIN_STOCK_EN
    parameter int                            STOCK_BITS  = 8,
    parameter int                            STOCK_INIT  = 10,
`endif
    parameter int                            WAIT_BITS   = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_COINS-1:0]  i_input_coin,
    input  logic                  i_item_dispensed,
    input  logic                  i_trigger_return,
    input  logic [TOTAL_BITS-1:0] i_total,
    input  logic                  i_coin_ready,
    output logic                  o_return_valid,
    output logic [NUM_COINS-1:0]  o_return_coin,
    output logic [TOTAL_BITS-1:0] o_return_value,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [TOTAL_BITS-1:0] o_residue,
`ifdef VM_COIN_STOCK_EN
    output logic [NUM_COINS-1:0]  o_stock_empty,
`endif
    output logic [WAIT_BITS-1:0]  o_wait_time
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RETURN = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [WAIT_BITS-1:0] WAIT_RELOAD = WAIT_BITS'(WAIT_CYCLES);

    state_t                  state_q, state_d;
    logic [WAIT_BITS-1:0]    wait_q, wait_d;
    logic [TOTAL_BITS-1:0]   remaining_q, remaining_d;

    logic                    activity;
    logic [NUM_COINS-1:0]    coin_avail;
    logic                    sel_found;
    logic [NUM_COINS-1:0]    sel_onehot;
    logic [TOTAL_BITS-1:0]   sel_value;
    logic                    transfer;

`ifdef VM_COIN_STOCK_EN
    localparam logic [STOCK_BITS-1:0] STOCK_RESET = STOCK_BITS'(STOCK_INIT);
    localparam logic [STOCK_BITS-1:0] STOCK_MAX   = {STOCK_BITS{1'b1}};

    logic [STOCK_BITS-1:0]   stock_q [NUM_COINS];
    logic [STOCK_BITS-1:0]   stock_d [NUM_COINS];
`endif

    assign activity = (|i_input_coin) | i_item_dispensed;

    // Coins eligible for the greedy select.
`ifdef VM_COIN_STOCK_EN
    always_comb begin
        coin_avail = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            coin_avail[i] = (stock_q[i] != '0);
        end
    end
`else
    assign coin_avail = '1;
`endif

    // Greedy select: denominations ascend with index, so the last fitting
    // index in an ascending scan is the largest coin that still fits.
    always_comb begin
        sel_found  = 1'b0;
        sel_onehot = '0;
        sel_value  = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (coin_avail[i] &&
                (TOTAL_BITS'(COIN_VALUES[i*VAL_BITS +: VAL_BITS]) <= remaining_q)) begin
                sel_found     = 1'b1;
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
                sel_value     = TOTAL_BITS'(COIN_VALUES[i*VAL_BITS +: VAL_BITS]);
            end
        end
    end

    assign transfer = (state_q == ST_RETURN) && sel_found && i_coin_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wait_q      <= WAIT_RELOAD;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            remaining_q <= remaining_d;
        end
    end

`ifdef VM_COIN_STOCK_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_COINS; i++) begin
                stock_q[i] <= STOCK_RESET;
            end
        end else begin
            for (int i = 0; i < NUM_COINS; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

    // Inserted coins are only counted while not paying out. Upstream rejects
    // coins during payout, so increment and decrement never coincide.
    always_comb begin
        for (int i = 0; i < NUM_COINS; i++) begin
            stock_d[i] = stock_q[i];
            if (transfer && sel_onehot[i]) begin
                stock_d[i] = stock_q[i] - STOCK_BITS'(1);
            end else if ((state_q != ST_RETURN) && i_input_coin[i] &&
                         (stock_q[i] != STOCK_MAX)) begin
                stock_d[i] = stock_q[i] + STOCK_BITS'(1);
            end
        end
    end
`endif

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        remaining_d = remaining_q;
        unique case (state_q)
            ST_IDLE: begin
                if (activity) begin
                    wait_d = WAIT_RELOAD;
                end else if ((i_trigger_return || (wait_q == '0)) && (i_total != '0)) begin
                    remaining_d = i_total;
                    state_d     = ST_RETURN;
                end else if (wait_q != '0) begin
                    wait_d = wait_q - WAIT_BITS'(1);
                end
            end
            ST_RETURN: begin
                // The countdown stays frozen during payout.
                if (!sel_found) begin
                    state_d = ST_DONE;
                end else if (i_coin_ready) begin
                    remaining_d = remaining_q - sel_value;
                end
            end
            ST_DONE: begin
                wait_d  = WAIT_RELOAD;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs. The presented coin comes straight from registered remaining,
    // so it holds stable for as long as the hopper stalls.
    always_comb begin
        o_busy         = (state_q == ST_RETURN);
        o_return_valid = (state_q == ST_RETURN) && sel_found;
        o_return_coin  = o_return_valid ? sel_onehot : '0;
        o_return_value = o_return_valid ? sel_value  : '0;
        o_done         = (state_q == ST_DONE);
        o_residue      = (state_q == ST_DONE) ? remaining_q : '0;
        o_wait_time    = wait_q;
    end

`ifdef VM_COIN_STOCK_EN
    assign o_stock_empty = ~coin_avail;
`endif

endmodule

// File: tb/tb_vm_change_dispenser.sv
// tb/tb_vm_change_dispenser.sv - randomized self-checking bench for vm_change_dispenser

module tb_vm_change_dispenser;

    localparam int NC = 3;
    localparam int TB = 31;
    localparam int WB = 8;
    localparam int WAIT_N = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NC-1:0] i_input_coin = '0;
    logic          i_item_dispensed = 1'b0;
    logic          i_trigger_return = 1'b0;
    logic [TB-1:0] i_total = '0;
    logic          i_coin_ready = 1'b1;
    logic          o_return_valid;
    logic [NC-1:0] o_return_coin;
    logic [TB-1:0] o_return_value;
    logic          o_busy;
    logic          o_done;
    logic [TB-1:0] o_residue;
    logic [WB-1:0] o_wait_time;

    int checks = 0;
    int errors = 0;

    vm_change_dispenser dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_input_coin     (i_input_coin),
        .i_item_dispensed (i_item_dispensed),
        .i_trigger_return (i_trigger_return),
        .i_total          (i_total),
        .i_coin_ready     (i_coin_ready),
        .o_return_valid   (o_return_valid),
        .o_return_coin    (o_return_coin),
        .o_return_value   (o_return_value),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_residue        (o_residue),
        .o_wait_time      (o_wait_time)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int onehot_of(input int value);
        case (value)
            1000:    return 4;
            500:     return 2;
            100:     return 1;
            default: return 0;
        endcase
    endfunction

    // Step to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full payout of 'total', started by trigger or by the inactivity timeout,
    // with an optional randomly stalling hopper.
    task automatic payout(input int total, input bit use_timeout, input bit stalls);
        int denoms[3] = '{1000, 500, 100};
        int exp_q[$];
        int rem;
        bit first;
        bit done_seen;
        bit prev_stall;
        logic [NC-1:0] prev_coin;
        logic [TB-1:0] prev_value;

        rem = total;
        foreach (denoms[d]) begin
            while (rem >= denoms[d]) begin
                exp_q.push_back(denoms[d]);
                rem -= denoms[d];
            end
        end

        if (use_timeout) begin
            i_total = TB'(total);
            i_item_dispensed = 1'b1;
            step();
            i_item_dispensed = 1'b0;
            for (int k = WAIT_N; k >= 0; k--) begin
                @(negedge clk);
                check_eq("countdown", o_wait_time, k);
                check_eq("countdown_busy", o_busy, 0);
                step();
            end
        end else begin
            i_total = TB'(total);
            i_trigger_return = 1'b1;
            step();
            i_trigger_return = 1'b0;
        end

        i_coin_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
        first = 1'b1;
        done_seen = 1'b0;
        prev_stall = 1'b0;
        prev_coin = '0;
        prev_value = '0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (first) begin
                check_eq("busy_enter", o_busy, 1);
                check_eq("first_valid", o_return_valid, exp_q.size() > 0);
                first = 1'b0;
            end
            if (prev_stall) begin
                check_eq("hold_valid", o_return_valid, 1);
                check_eq("hold_coin", o_return_coin, prev_coin);
                check_eq("hold_value", o_return_value, prev_value);
            end
            if (o_done) begin
                check_eq("residue", o_residue, rem);
                check_eq("coins_left", exp_q.size(), 0);
                done_seen = 1'b1;
                break;
            end
            if (o_return_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_coin", o_return_value, 0);
                end else begin
                    check_eq("coin_value", o_return_value, exp_q[0]);
                    check_eq("coin_onehot", o_return_coin, onehot_of(exp_q[0]));
                    if (i_coin_ready) begin
                        void'(exp_q.pop_front());
                        i_total = i_total - o_return_value;
                    end
                end
            end else begin
                check_eq("idle_coin", o_return_coin, 0);
            end
            prev_stall = o_return_valid && !i_coin_ready;
            prev_coin = o_return_coin;
            prev_value = o_return_value;
            step();
            i_coin_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        if (!done_seen) begin
            check_eq("done_timeout", 0, 1);
        end
        step();
        i_total = '0;
        i_coin_ready = 1'b1;
        @(negedge clk);
        check_eq("after_done", o_done, 0);
        check_eq("after_busy", o_busy, 0);
        check_eq("after_wait", o_wait_time, WAIT_N);
        step();
    endtask

    initial begin
        int dones;

        // Reset state
        reset_n = 1'b0;
        step();
        step();
        @(negedge clk);
        check_eq("rst_wait", o_wait_time, WAIT_N);
        check_eq("rst_valid", o_return_valid, 0);
        check_eq("rst_coin", o_return_coin, 0);
        check_eq("rst_value", o_return_value, 0);
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_done", o_done, 0);
        check_eq("rst_residue", o_residue, 0);
        step();
        reset_n = 1'b1;

        // Directed payouts: 1700 by trigger, 600 by timeout, 1000 with stalls,
        // 50 which cannot be paid at all.
        payout(1700, 1'b0, 1'b0);
        payout(600, 1'b1, 1'b0);
        payout(1000, 1'b0, 1'b1);
        payout(50, 1'b0, 1'b0);

        // Activity beats a same-cycle trigger.
        i_total = TB'(500);
        i_input_coin = 3'b001;
        i_trigger_return = 1'b1;
        step();
        i_input_coin = '0;
        i_trigger_return = 1'b0;
        i_total = '0;
        @(negedge clk);
        check_eq("act_wait", o_wait_time, WAIT_N);
        check_eq("act_busy", o_busy, 0);
        check_eq("act_valid", o_return_valid, 0);
        step();

        // Trigger with an empty balance does not start a payout.
        i_trigger_return = 1'b1;
        step();
        i_trigger_return = 1'b0;
        @(negedge clk);
        check_eq("zero_busy", o_busy, 0);
        step();

        // Reset in the middle of a payout of 1600.
        i_total = TB'(1600);
        i_trigger_return = 1'b1;
        step();
        i_trigger_return = 1'b0;
        @(negedge clk);
        check_eq("mid_value", o_return_value, 1000);
        step();
        reset_n = 1'b0;
        i_total = '0;
        step();
        @(negedge clk);
        check_eq("mid_rst_valid", o_return_valid, 0);
        check_eq("mid_rst_busy", o_busy, 0);
        check_eq("mid_rst_done", o_done, 0);
        check_eq("mid_rst_wait", o_wait_time, WAIT_N);
        step();
        reset_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (o_done) dones++;
            step();
        end
        check_eq("mid_rst_no_done", dones, 0);

        // Randomized payouts.
        for (int r = 0; r < 25; r++) begin
            payout($urandom_range(1, 60) * 50, $urandom_range(0, 1), $urandom_range(0, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "simulation time bound exceeded");
    end

endmodule
